// File: rtl/rgb2bayer_if.sv
// AXI4-Stream style bundle used for both the RGB input and the Bayer output.
// The width parameter covers the packed payload.
interface rgb2bayer_if #(
  parameter int W = 10
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tuser;
  logic         tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/rgb2bayer.sv
// RGB to Bayer re-mosaic. One component is selected per pixel from the CFA
// pattern latched at start of frame and the current row/column parity. The
// sample goes into an output register backed by a single skid register.
// Line and frame geometry are checked against the expected image size.
module rgb2bayer #(
  parameter int DATA_WIDTH = 10,
  parameter int RGB_WIDTH  = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  rgb2bayer_if.slave  s_axis,
  rgb2bayer_if.master m_axis,
  input  logic [1:0]  bayerType,
  output logic        line_len_err,
  output logic        frame_len_err,
  input  logic        err_clr
);

  logic                  acc;
  logic                  tready_q;
  logic [1:0]            pat_q, pat_eff;
  logic                  col_odd, row_odd, col_eff, row_eff;
  logic [RGB_WIDTH-1:0]  comp_r, comp_g, comp_b, comp;
  logic [DATA_WIDTH-1:0] sample;

  logic                  o_valid, o_user, o_last;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  k_valid, k_user, k_last, k_valid_n;
  logic [DATA_WIDTH-1:0] k_data;

  logic [11:0]           pix_cnt, line_cnt, pix_base, pix_next, line_base;
  logic                  seen_sof, line_set, frame_set;

  assign acc           = s_axis.tvalid && tready_q;
  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = o_valid;
  assign m_axis.tdata  = o_data;
  assign m_axis.tuser  = o_user;
  assign m_axis.tlast  = o_last;

  assign comp_r = s_axis.tdata[RGB_WIDTH-1:0];
  assign comp_g = s_axis.tdata[2*RGB_WIDTH-1:RGB_WIDTH];
  assign comp_b = s_axis.tdata[3*RGB_WIDTH-1:2*RGB_WIDTH];

  // Start-of-frame pixel uses the incoming pattern and forces parity to (0,0).
  always_comb begin
    pat_eff = s_axis.tuser ? bayerType : pat_q;
    col_eff = s_axis.tuser ? 1'b0 : col_odd;
    row_eff = s_axis.tuser ? 1'b0 : row_odd;
  end

  // CFA lookup: index is {row, col} parity.
  always_comb begin
    comp = comp_g;
    case (pat_eff)
      2'b00: begin
        if ({row_eff, col_eff} == 2'b00) comp = comp_b;
        else if ({row_eff, col_eff} == 2'b11) comp = comp_r;
      end
      2'b01: begin
        if ({row_eff, col_eff} == 2'b01) comp = comp_b;
        else if ({row_eff, col_eff} == 2'b10) comp = comp_r;
      end
      2'b10: begin
        if ({row_eff, col_eff} == 2'b01) comp = comp_r;
        else if ({row_eff, col_eff} == 2'b10) comp = comp_b;
      end
      default: begin
        if ({row_eff, col_eff} == 2'b00) comp = comp_r;
        else if ({row_eff, col_eff} == 2'b11) comp = comp_b;
      end
    endcase
  end

  generate
    if (DATA_WIDTH >= RGB_WIDTH) begin : g_extend
      assign sample = DATA_WIDTH'(comp) << (DATA_WIDTH - RGB_WIDTH);
    end else begin : g_truncate
      assign sample = comp[RGB_WIDTH-1 -: DATA_WIDTH];
    end
  endgenerate

  // Skid fills only when the output register is stalled and a pixel arrives.
  always_comb begin
    k_valid_n = k_valid;
    if (!o_valid || m_axis.tready) k_valid_n = 1'b0;
    else if (acc)                  k_valid_n = 1'b1;
  end

  // Output register plus skid; tready is registered as "skid empty".
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      tready_q <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_user   <= 1'b0;
      o_last   <= 1'b0;
      k_valid  <= 1'b0;
      k_data   <= '0;
      k_user   <= 1'b0;
      k_last   <= 1'b0;
    end else begin
      tready_q <= !k_valid_n;
      k_valid  <= k_valid_n;
      if (!o_valid || m_axis.tready) begin
        if (k_valid) begin
          o_valid <= 1'b1;
          o_data  <= k_data;
          o_user  <= k_user;
          o_last  <= k_last;
        end else if (acc) begin
          o_valid <= 1'b1;
          o_data  <= sample;
          o_user  <= s_axis.tuser;
          o_last  <= s_axis.tlast;
        end else begin
          o_valid <= 1'b0;
        end
      end else if (acc) begin
        k_data <= sample;
        k_user <= s_axis.tuser;
        k_last <= s_axis.tlast;
      end
    end
  end

  // Pattern latch and row/column parity tracking.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= 2'b00;
      col_odd <= 1'b0;
      row_odd <= 1'b0;
    end else if (acc) begin
      if (s_axis.tuser) pat_q <= bayerType;
      col_odd <= s_axis.tlast ? 1'b0 : !col_eff;
      row_odd <= s_axis.tlast ? !row_eff : row_eff;
    end
  end

  // A tuser with a partly received line counts that line as short.
  always_comb begin
    pix_base  = s_axis.tuser ? 12'd0 : pix_cnt;
    pix_next  = (pix_base == 12'hFFF) ? pix_base : pix_base + 12'd1;
    line_base = s_axis.tuser ? 12'd0 : line_cnt;
    line_set  = acc && ((s_axis.tuser && pix_cnt != 12'd0) ||
                        (s_axis.tlast && pix_next != 12'(IMG_WIDTH)));
    frame_set = acc && s_axis.tuser && seen_sof && (line_cnt != 12'(IMG_HEIGHT));
  end

  // Geometry counters and sticky error flags (a set beats a clear).
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt       <= '0;
      line_cnt      <= '0;
      seen_sof      <= 1'b0;
      line_len_err  <= 1'b0;
      frame_len_err <= 1'b0;
    end else begin
      if (acc) begin
        pix_cnt <= s_axis.tlast ? 12'd0 : pix_next;
        if (s_axis.tuser) seen_sof <= 1'b1;
        if (s_axis.tlast && line_base != 12'hFFF) line_cnt <= line_base + 12'd1;
        else                                      line_cnt <= line_base;
      end
      line_len_err  <= line_set  | (line_len_err  & !err_clr);
      frame_len_err <= frame_set | (frame_len_err & !err_clr);
    end
  end

endmodule
